// File: rtl/reg_display_scanner_if.sv
// Register-file debug port bundle for reg_display_scanner.
//   dispSel : register index presented to the regfile debug port
//   dispDat : register value returned combinationally for dispSel
// Modports:
//   master : scanner side (drives dispSel, reads dispDat)
//   slave  : regfile side (reads dispSel, drives dispDat)
interface reg_display_scanner_if;
  logic [4:0]  dispSel;
  logic [31:0] dispDat;

  modport master (output dispSel, input dispDat);
  modport slave  (input dispSel, output dispDat);
endinterface

// File: rtl/reg_display_scanner.sv
// reg_display_scanner: shows one 32-bit register as 8 hex digits on a
// multiplexed seven-segment display. Each frame selects a register index,
// captures its value into a shadow register, then scans the 8 digits.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   sel_in   : manual register index (switches)
//   auto     : 1 = auto-scan registers, 0 = manual index
//   hold     : 1 = freeze the auto-scan index and frame counter
//   dbg      : regfile debug port (dispSel out, dispDat in)
//   an       : digit anodes, active-low, an[0] = rightmost
//   seg      : cathodes {g,f,e,d,c,b,a}, active-low
//   dp       : decimal point, active-low (lit on digit 4)
//   cur_idx  : index of the register held in the shadow
//
// Parameters:
//   REFRESH_DIV : clk cycles each digit is lit (2..2^20)
//   SCAN_FRAMES : frames shown per register in auto mode (1..2^16)
//
// Build option:
//   DISP_AUTOSCAN_EN : when defined, auto/hold select an auto-incrementing
//                      index with a frame counter; otherwise both inputs are
//                      ignored and the index is always sel_in.
module reg_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SCAN_FRAMES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            sel_in,
  input  logic                  auto,
  input  logic                  hold,
  reg_display_scanner_if.master dbg,
  output logic [7:0]            an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [4:0]            cur_idx
);

  localparam logic [1:0] SEL     = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SCAN    = 2'd2;

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [1:0]    state;
  logic [RW-1:0] ref_cnt;
  logic [2:0]    digit;
  logic [31:0]   shadow;
  logic [4:0]    sel_q;
  logic [4:0]    next_sel;
  logic          frame_done;
  logic [3:0]    nibble;

  assign dbg.dispSel = sel_q;
  assign frame_done  = (state == SCAN) && (digit == 3'd7) && (ref_cnt == REF_LAST);

`ifdef DISP_AUTOSCAN_EN
  localparam int unsigned FW = (SCAN_FRAMES > 1) ? $clog2(SCAN_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCAN_FRAMES - 1);

  logic [4:0]    auto_idx;
  logic [FW-1:0] frame_cnt;

  assign next_sel = auto ? auto_idx : sel_in;

  // Frames are only counted while auto-scanning and not held, so leaving
  // and re-entering auto mode resumes with the retained count and index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_idx  <= '0;
      frame_cnt <= '0;
    end else if (frame_done && auto && !hold) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        auto_idx  <= auto_idx + 5'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_auto_ctrl;
  assign unused_auto_ctrl = ^{auto, hold};
  assign next_sel = sel_in;
`endif

  // dispSel is registered as SEL completes, so it is steady for the whole
  // CAPTURE cycle in which the regfile value is latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SEL;
      sel_q   <= '0;
      cur_idx <= '0;
      shadow  <= '0;
      digit   <= '0;
      ref_cnt <= '0;
    end else begin
      case (state)
        SEL: begin
          sel_q <= next_sel;
          state <= CAPTURE;
        end
        CAPTURE: begin
          shadow  <= dbg.dispDat;
          cur_idx <= sel_q;
          digit   <= '0;
          ref_cnt <= '0;
          state   <= SCAN;
        end
        SCAN: begin
          if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            if (digit == 3'd7) begin
              state <= SEL;
            end else begin
              digit <= digit + 3'd1;
            end
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        default: state <= SEL;
      endcase
    end
  end

  assign nibble = 4'(shadow >> {digit, 2'b00});

  // Outputs decode straight from state so reset blanks the display at once.
  always_comb begin
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    if (state == SCAN) begin
      an = ~(8'b1 << digit);
      dp = (digit != 3'd4);
      case (nibble)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Self-checking bench for reg_display_scanner (REFRESH_DIV=4, SCAN_FRAMES=2).
// A regfile array answers the debug port; each frame is checked cycle by
// cycle against the expected digit sequence derived from the register value.
module tb_reg_display_scanner;

  localparam int unsigned RDIV = 4;
  localparam int unsigned SFR  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sel_in;
  logic       auto;
  logic       hold;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [4:0] cur_idx;

  logic [31:0] regfile [32];
  logic [6:0]  hex_tab [16];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the auto-scan index and frame count.
  int m_idx = 0;
  int m_cnt = 0;

  reg_display_scanner_if bus ();
  assign bus.dispDat = regfile[bus.dispSel];

  reg_display_scanner #(
    .REFRESH_DIV (RDIV),
    .SCAN_FRAMES (SFR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel_in  (sel_in),
    .auto    (auto),
    .hold    (hold),
    .dbg     (bus.master),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .cur_idx (cur_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  function automatic logic [4:0] exp_sel();
`ifdef DISP_AUTOSCAN_EN
    return auto ? 5'(m_idx) : sel_in;
`else
    return sel_in;
`endif
  endfunction

  // Entered at a falling edge inside the SEL cycle; leaves at the falling
  // edge inside the next SEL cycle. chg >= 0 changes sel_in during digit 3.
  task automatic run_frame(input logic [4:0] idx, input int chg);
    logic [31:0] val;
    logic [7:0]  want_an;
    val = regfile[idx];
    check("sel_an", an, 8'hFF);
    check("sel_seg", seg, 7'h7F);
    check("sel_dp", dp, 1'b1);
    @(posedge clk); @(negedge clk);
    check("cap_dispSel", bus.dispSel, idx);
    check("cap_an", an, 8'hFF);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < int'(RDIV); k++) begin
        @(posedge clk); @(negedge clk);
        if (d == 0 && k == 0) check("cur_idx", cur_idx, idx);
        if (chg >= 0 && d == 3 && k == 0) sel_in = 5'(chg);
        want_an = 8'hFF;
        want_an[d] = 1'b0;
        check("scan_an", an, want_an);
        check("scan_seg", seg, hex_tab[(val / (32'd1 << (4 * d))) % 16]);
        check("scan_dp", dp, (d == 4) ? 1'b0 : 1'b1);
      end
    end
`ifdef DISP_AUTOSCAN_EN
    if (auto && !hold) begin
      m_cnt++;
      if (m_cnt == int'(SFR)) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 32;
      end
    end
`endif
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[5] = 32'h1234ABCD;

    reset  = 1'b0;
    sel_in = 5'd5;
    auto   = 1'b0;
    hold   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_dispSel", bus.dispSel, 5'd0);
    check("rst_cur_idx", cur_idx, 5'd0);
    reset = 1'b1;

    // Manual index 5, then a mid-frame change to 9.
    run_frame(exp_sel(), -1);
    run_frame(exp_sel(), 9);
    run_frame(exp_sel(), -1);
    check("sel_in_applied", bus.dispSel, 5'd9);

    // Random manual indices.
    for (int i = 0; i < 3; i++) begin
      sel_in = 5'($urandom_range(31));
      run_frame(exp_sel(), -1);
    end

    // Reset asserted mid-SCAN blanks immediately.
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_an", an, 8'hFF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1'b1);
    @(negedge clk);
    check("async_dispSel", bus.dispSel, 5'd0);
    check("async_cur_idx", cur_idx, 5'd0);
    sel_in = 5'd0;
    m_idx = 0;
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    run_frame(exp_sel(), -1);

`ifdef DISP_AUTOSCAN_EN
    // Auto scan through all 32 indices (two frames each) and wrap to 0.
    auto = 1'b1;
    for (int f = 0; f < 64; f++) run_frame(exp_sel(), -1);
    run_frame(exp_sel(), -1);
    while (m_idx != 7) run_frame(exp_sel(), -1);
    hold = 1'b1;
    for (int f = 0; f < 10; f++) run_frame(exp_sel(), -1);
    check("hold_dispSel", bus.dispSel, 5'd7);
    hold = 1'b0;
    for (int f = 0; f < 4; f++) run_frame(exp_sel(), -1);
    // Leave auto mode and come back: index is retained.
    auto = 1'b0;
    sel_in = 5'd20;
    run_frame(exp_sel(), -1);
    auto = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(exp_sel(), -1);
`else
    // auto/hold are ignored in this build.
    auto = 1'b1;
    sel_in = 5'd3;
    for (int f = 0; f < 10; f++) begin
      hold = f[0];
      run_frame(5'd3, -1);
    end
    check("noauto_dispSel", bus.dispSel, 5'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
